// File: rtl/traffic_pkg.sv
// Shared traffic-light constants: display segment patterns, default phase lengths,
// the countdown state type and a binary-to-two-digit splitter.
package traffic_pkg;

  localparam int unsigned TX_SEC        = 30;
  localparam int unsigned TY_SEC        = 15;
  localparam int unsigned TICKS_PER_SEC = 10;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Segment order {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  typedef enum logic {
    StIdle,
    StCount
  } cd_state_e;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } digits_t;

  // Restoring compare-and-subtract on the tens weights 80/40/20/10; valid for 0..99.
  function automatic digits_t bcd_split(input logic [6:0] value);
    logic [6:0] rest;
    digits_t    d;
    rest   = value;
    d.tens = 4'd0;
    if (rest >= 7'd80) begin
      rest      = rest - 7'd80;
      d.tens[3] = 1'b1;
    end
    if (rest >= 7'd40) begin
      rest      = rest - 7'd40;
      d.tens[2] = 1'b1;
    end
    if (rest >= 7'd20) begin
      rest      = rest - 7'd20;
      d.tens[1] = 1'b1;
    end
    if (rest >= 7'd10) begin
      rest      = rest - 7'd10;
      d.tens[0] = 1'b1;
    end
    d.ones = 4'(rest);
    return d;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder with a blank override.
// Non-decimal codes decode to a dark digit.
module bcd_to_seg7 (
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);
  import traffic_pkg::*;

  always_comb begin
    seg = SEG_BLANK;
    if (!blank && (bcd <= 4'd9)) begin
      seg = SEG_DIGIT[bcd];
    end
  end

endmodule

// File: rtl/countdown_seg_driver.sv
// Phase countdown for the light controller with a two-digit multiplexed display.
// Define COUNTDOWN_BLINK_EN to blink the display during the last five seconds.
module countdown_seg_driver #(
  parameter int unsigned TX            = traffic_pkg::TX_SEC,
  parameter int unsigned TY            = traffic_pkg::TY_SEC,
  parameter int unsigned TICKS_PER_SEC = traffic_pkg::TICKS_PER_SEC,
  parameter int unsigned SCAN_DIV      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       seg_signal,
  output logic [6:0] remaining,
  output logic       busy,
  output logic [6:0] seg,
  output logic [1:0] an
);
  import traffic_pkg::*;

  localparam int unsigned SubW  = $clog2(TICKS_PER_SEC);
  localparam int unsigned ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [SubW-1:0]  SubLast  = SubW'(TICKS_PER_SEC - 1);
  localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_DIV - 1);
  localparam logic [6:0]       LoadX    = 7'(TX);
  localparam logic [6:0]       LoadY    = 7'(TY);

  logic             seg_q;
  logic [6:0]       rem_q;
  logic [SubW-1:0]  sub_q;
  logic [ScanW-1:0] scan_q, scan_d;
  logic [1:0]       an_q, an_d;
  logic [6:0]       seg_out_q, seg_d;
  logic             rise, fall;
  cd_state_e        state;
  digits_t          digits;
  logic [3:0]       dec_bcd;
  logic             dec_blank;

  assign rise  = seg_signal & ~seg_q;
  assign fall  = ~seg_signal & seg_q;
  assign state = (rem_q == 7'd0) ? StIdle : StCount;

  // Countdown state: a fresh edge always wins over the running count.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= 1'b0;
      rem_q <= 7'd0;
      sub_q <= '0;
    end else begin
      seg_q <= seg_signal;
      if (rise) begin
        rem_q <= LoadX;
        sub_q <= '0;
      end else if (fall) begin
        rem_q <= LoadY;
        sub_q <= '0;
      end else begin
        unique case (state)
          StCount: begin
            if (sub_q == SubLast) begin
              sub_q <= '0;
              rem_q <= rem_q - 7'd1;
            end else begin
              sub_q <= sub_q + SubW'(1);
            end
          end
          StIdle: begin
            rem_q <= 7'd0;
            sub_q <= '0;
          end
        endcase
      end
    end
  end

  // an_q==0 only right after reset; the first selection is the ones digit.
  always_comb begin
    an_d   = an_q;
    scan_d = scan_q;
    if (an_q == 2'b00) begin
      an_d   = 2'b01;
      scan_d = '0;
    end else if (scan_q == ScanLast) begin
      an_d   = ~an_q;
      scan_d = '0;
    end else begin
      scan_d = scan_q + ScanW'(1);
    end
  end

  // Decode for the digit selected next cycle so seg and an stay aligned.
  always_comb begin
    digits    = bcd_split(rem_q);
    dec_bcd   = an_d[1] ? digits.tens : digits.ones;
    dec_blank = an_d[1] && (digits.tens == 4'd0);
`ifdef COUNTDOWN_BLINK_EN
    if ((rem_q >= 7'd1) && (rem_q <= 7'd5) && (sub_q >= SubW'(TICKS_PER_SEC / 2))) begin
      dec_blank = 1'b1;
    end
`endif
  end

  bcd_to_seg7 u_bcd_to_seg7 (
    .bcd   (dec_bcd),
    .blank (dec_blank),
    .seg   (seg_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      an_q      <= 2'b00;
      scan_q    <= '0;
      seg_out_q <= SEG_BLANK;
    end else begin
      an_q      <= an_d;
      scan_q    <= scan_d;
      seg_out_q <= seg_d;
    end
  end

  assign remaining = rem_q;
  assign busy      = (rem_q != 7'd0);
  assign seg       = seg_out_q;
  assign an        = an_q;

endmodule

// File: tb/tb_countdown_seg_driver.sv
// Bench for countdown_seg_driver: stimulus table with spot expectations plus a
// per-edge closed-form reference, both fed through one scoreboard queue.
module tb_countdown_seg_driver;

  localparam int TX   = 30;
  localparam int TY   = 15;
  localparam int TPS  = 10;
  localparam int SCAN = 4;
  localparam int NVEC = 25;

  logic       clk = 1'b0;
  logic       rst;
  logic       seg_signal;
  logic [6:0] remaining;
  logic       busy;
  logic [6:0] seg;
  logic [1:0] an;

  countdown_seg_driver #(
    .TX            (TX),
    .TY            (TY),
    .TICKS_PER_SEC (TPS),
    .SCAN_DIV      (SCAN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_signal (seg_signal),
    .remaining  (remaining),
    .busy       (busy),
    .seg        (seg),
    .an         (an)
  );

  always #5 clk = ~clk;

  typedef struct {
    string    tag;
    int       rem;
    bit       busy;
    bit [1:0] an;
    bit [6:0] seg;
  } exp_t;

  typedef struct {
    bit       rst;
    bit       sig;
    int       cycles;
    int       rem;
    bit       busy;
    bit [1:0] an;
    bit [6:0] seg;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[NVEC];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference state: edge number, last load edge/value, first edge after reset.
  int e        = 0;
  int le       = -1;
  int lv       = 0;
  int rel_e    = 0;
  int rem_prev = 0;
  int sub_prev = 0;
  bit sig_prev = 1'b0;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input int want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endtask

  task automatic model_push(input bit r, input bit s);
    exp_t x;
    int   rem;
    int   sub;
    x.tag = $sformatf("edge%0d", e);
    if (r) begin
      x.rem    = 0;
      x.busy   = 1'b0;
      x.an     = 2'b00;
      x.seg    = 7'h00;
      rel_e    = e + 1;
      le       = -1;
      sig_prev = 1'b0;
      rem_prev = 0;
      sub_prev = 0;
    end else begin
      if (s && !sig_prev) begin
        le = e;
        lv = TX;
      end else if (!s && sig_prev) begin
        le = e;
        lv = TY;
      end
      sig_prev = s;
      rem = (le < 0) ? 0 : lv - (e - le) / TPS;
      if (rem < 0) rem = 0;
      sub    = (rem != 0) ? (e - le) % TPS : 0;
      x.rem  = rem;
      x.busy = (rem != 0);
      x.an   = (((e - rel_e) / SCAN) % 2 == 0) ? 2'b01 : 2'b10;
      if (x.an == 2'b01) x.seg = seg_of(rem_prev % 10);
      else               x.seg = (rem_prev / 10 == 0) ? 7'h00 : seg_of(rem_prev / 10);
`ifdef COUNTDOWN_BLINK_EN
      if (rem_prev >= 1 && rem_prev <= 5 && sub_prev >= TPS / 2) x.seg = 7'h00;
`endif
      rem_prev = rem;
      sub_prev = sub;
    end
    sb.push_back(x);
  endtask

  task automatic drain();
    exp_t x;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      chk({x.tag, " remaining"}, 32'(remaining), x.rem);
      chk({x.tag, " busy"},      32'(busy),      int'(x.busy));
      chk({x.tag, " an"},        32'(an),        int'(x.an));
      chk({x.tag, " seg"},       32'(seg),       int'(x.seg));
    end
  endtask

  task automatic run_vec(input int idx);
    exp_t t;
    for (int c = 0; c < vecs[idx].cycles; c++) begin
      rst        = vecs[idx].rst;
      seg_signal = vecs[idx].sig;
      e++;
      model_push(vecs[idx].rst, vecs[idx].sig);
      if (c == vecs[idx].cycles - 1) begin
        t.tag  = $sformatf("vec%0d", idx);
        t.rem  = vecs[idx].rem;
        t.busy = vecs[idx].busy;
        t.an   = vecs[idx].an;
        t.seg  = vecs[idx].seg;
        sb.push_back(t);
      end
      @(posedge clk);
      #1;
      drain();
    end
  endtask

  initial begin
    rst        = 1'b1;
    seg_signal = 1'b0;
    //            rst   sig   cyc  rem busy  an     seg        edge
    vecs[0]  = '{1'b1, 1'b0, 2,   0,  1'b0, 2'b00, 7'h00};  // 2
    vecs[1]  = '{1'b0, 1'b0, 1,   0,  1'b0, 2'b01, 7'h3F};  // 3
    vecs[2]  = '{1'b0, 1'b0, 4,   0,  1'b0, 2'b10, 7'h00};  // 7
    vecs[3]  = '{1'b0, 1'b0, 4,   0,  1'b0, 2'b01, 7'h3F};  // 11
    vecs[4]  = '{1'b0, 1'b1, 1,   30, 1'b1, 2'b01, 7'h3F};  // 12 rise
    vecs[5]  = '{1'b0, 1'b1, 10,  29, 1'b1, 2'b01, 7'h3F};  // 22
    vecs[6]  = '{1'b0, 1'b1, 289, 1,  1'b1, 2'b10, 7'h00};  // 311
    vecs[7]  = '{1'b0, 1'b1, 1,   0,  1'b0, 2'b10, 7'h00};  // 312
    vecs[8]  = '{1'b0, 1'b1, 20,  0,  1'b0, 2'b01, 7'h3F};  // 332 idle holds
    vecs[9]  = '{1'b0, 1'b0, 5,   15, 1'b1, 2'b10, 7'h06};  // 337 fall at 333
    vecs[10] = '{1'b0, 1'b0, 150, 0,  1'b0, 2'b10, 7'h00};  // 487
    vecs[11] = '{1'b0, 1'b1, 1,   30, 1'b1, 2'b10, 7'h00};  // 488 rise
    vecs[12] = '{1'b0, 1'b1, 100, 20, 1'b1, 2'b01, 7'h06};  // 588
    vecs[13] = '{1'b0, 1'b0, 1,   15, 1'b1, 2'b01, 7'h3F};  // 589 fall reloads
    vecs[14] = '{1'b0, 1'b0, 10,  14, 1'b1, 2'b10, 7'h06};  // 599
    vecs[15] = '{1'b0, 1'b0, 50,  9,  1'b1, 2'b10, 7'h06};  // 649
    vecs[16] = '{1'b0, 1'b0, 4,   9,  1'b1, 2'b01, 7'h6F};  // 653
    vecs[17] = '{1'b0, 1'b0, 4,   9,  1'b1, 2'b10, 7'h00};  // 657 tens blanked
    vecs[18] = '{1'b0, 1'b1, 1,   30, 1'b1, 2'b10, 7'h00};  // 658 rise
    vecs[19] = '{1'b0, 1'b1, 130, 17, 1'b1, 2'b01, 7'h7F};  // 788
    vecs[20] = '{1'b1, 1'b1, 1,   0,  1'b0, 2'b00, 7'h00};  // 789 reset mid-count
    vecs[21] = '{1'b0, 1'b1, 1,   30, 1'b1, 2'b01, 7'h3F};  // 790 high after reset
    vecs[22] = '{1'b0, 1'b1, 270, 3,  1'b1, 2'b10, 7'h00};  // 1060
    vecs[23] = '{1'b0, 1'b1, 5,   3,  1'b1, 2'b01, 7'h4F};  // 1065
    vecs[24] = '{1'b0, 1'b1, 40,  0,  1'b0, 2'b01, 7'h3F};  // 1105
    for (int i = 0; i < NVEC; i++) begin
      run_vec(i);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
